// File: rtl/rss_sampler.sv
// rss_sampler: power-up, settle and averaging sequencer for the LT5534 RSS
// detector and its serial ADC.
//
// A start pulse enables the detector, waits SETTLE_CYCLES, then runs
// 2^AVG_LOG2 SPI conversion frames separated by QUIET_CYCLES of CS-high time.
// The truncated mean of the frame results is presented on rss with a
// one-cycle rss_valid strobe.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   start      one-cycle request pulse, ignored while busy
//   abort      cancel any sequence in progress (rss is kept)
//   lt5534_en  detector enable, high exactly while busy
//   adc_cs     ADC chip select, active-low
//   dc_clk     ADC serial clock, idles high
//   adc_so     ADC serial data, sampled on dc_clk rising, MSB first
//   busy       sequence in progress
//   rss        averaged RSS code, holds the last completed result
//   rss_valid  one-cycle strobe accompanying a new rss
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | detector off, waiting for start
// S_SETTLE | detector on, waiting for its output to settle
// S_FRAME  | CS low, clocking one conversion frame
// S_QUIET  | CS high between frames
// S_DONE   | result published, one cycle before returning to idle
module rss_sampler #(
  parameter int HALF_PERIOD   = 25,
  parameter int FRAME_BITS    = 16,
  parameter int DATA_BITS     = 12,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 50,
  parameter int QUIET_CYCLES  = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 lt5534_en,
  output logic                 adc_cs,
  output logic                 dc_clk,
  input  logic                 adc_so,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rss,
  output logic                 rss_valid
);

  localparam int NUM_FRAMES = 1 << AVG_LOG2;
  localparam int ACC_W      = DATA_BITS + AVG_LOG2;
  // A frame is 2*FRAME_BITS+1 half periods: one leading half period with
  // dc_clk high, FRAME_BITS full clocks, and the final CS-rise half period.
  localparam int LAST_PHASE = 2 * FRAME_BITS;
  localparam int T_MAX0     = (SETTLE_CYCLES > QUIET_CYCLES) ? SETTLE_CYCLES : QUIET_CYCLES;
  localparam int T_MAX      = (T_MAX0 > HALF_PERIOD) ? T_MAX0 : HALF_PERIOD;
  localparam int TW         = $clog2(T_MAX + 1);
  localparam int PW         = $clog2(LAST_PHASE + 1);
  localparam int FW         = AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_FRAME  = 3'd2,
    S_QUIET  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        timer;
  logic [PW-1:0]        phase;
  logic [FW-1:0]        frame_cnt;
  // Only the last DATA_BITS bits shifted in form the result; earlier bits
  // simply fall off the top.
  logic [DATA_BITS-1:0] shift;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;

  logic tc, half_evt, cs_rise, sclk_rise, sclk_fall, last_frame;
  logic cs_nxt, dc_nxt, busy_nxt;

  assign tc         = (timer == '0);
  assign half_evt   = (state == S_FRAME) && tc;
  assign cs_rise    = half_evt && (phase == PW'(LAST_PHASE));
  // phase counts completed half periods; an odd count means the half period
  // ending now is an even one, i.e. a dc_clk rising edge.
  assign sclk_rise  = half_evt && phase[0];
  assign sclk_fall  = half_evt && !phase[0] && !cs_rise;
  assign last_frame = (frame_cnt == FW'(NUM_FRAMES - 1));
  assign acc_sum    = acc + ACC_W'(shift);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (tc) state_nxt = S_FRAME;
      S_FRAME:  if (cs_rise) state_nxt = last_frame ? S_DONE : S_QUIET;
      S_QUIET:  if (tc) state_nxt = S_FRAME;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Next values of the registered pins; dc_clk is forced high whenever CS
  // will be high so it can never toggle outside a frame.
  always_comb begin
    cs_nxt   = 1'b1;
    dc_nxt   = 1'b1;
    busy_nxt = (state_nxt != S_IDLE);
    if (state_nxt == S_FRAME) begin
      cs_nxt = 1'b0;
      dc_nxt = dc_clk;
      if (sclk_fall)      dc_nxt = 1'b0;
      else if (sclk_rise) dc_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      phase     <= '0;
      frame_cnt <= '0;
      shift     <= '0;
      acc       <= '0;
      adc_cs    <= 1'b1;
      dc_clk    <= 1'b1;
      lt5534_en <= 1'b0;
      busy      <= 1'b0;
      rss       <= '0;
      rss_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      adc_cs    <= cs_nxt;
      dc_clk    <= dc_nxt;
      busy      <= busy_nxt;
      lt5534_en <= busy_nxt;
      rss_valid <= 1'b0;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              timer     <= TW'(SETTLE_CYCLES - 1);
              acc       <= '0;
              frame_cnt <= '0;
            end
          end
          S_SETTLE, S_QUIET: begin
            if (tc) begin
              timer <= TW'(HALF_PERIOD - 1);
              phase <= '0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          S_FRAME: begin
            if (tc) begin
              timer <= TW'(HALF_PERIOD - 1);
              phase <= phase + PW'(1);
              if (sclk_rise) shift <= {shift[DATA_BITS-2:0], adc_so};
              if (cs_rise) begin
                if (last_frame) begin
                  rss       <= DATA_BITS'(acc_sum >> AVG_LOG2);
                  rss_valid <= 1'b1;
                end else begin
                  acc       <= acc_sum;
                  frame_cnt <= frame_cnt + FW'(1);
                  timer     <= TW'(QUIET_CYCLES - 1);
                end
              end
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rss_sampler.sv
// tb_rss_sampler: scoreboard bench for rss_sampler.
// Instance a uses default parameters, instance b the fast corner
// (HALF_PERIOD=1, AVG_LOG2=0, SETTLE_CYCLES=1, QUIET_CYCLES=1).
module tb_rss_sampler;

  localparam int FB = 16;
  localparam int DB = 12;

  localparam int HA = 25, AA = 2, SA = 50, QA = 50;
  localparam int NA = 1 << AA;
  localparam int WIN_A = (2 * FB + 1) * HA;
  localparam int LAT_A = SA + (NA - 1) * (WIN_A + QA) + WIN_A;

  localparam int HB = 1, AB = 0, SB = 1, QB = 1;
  localparam int WIN_B = (2 * FB + 1) * HB;
  localparam int LAT_B = SB + WIN_B;

  typedef struct {
    int rss;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, so_a = 1'b0;
  logic start_b = 1'b0, abort_b = 1'b0, so_b = 1'b0;
  logic en_a, cs_a, dc_a, busy_a, valid_a;
  logic en_b, cs_b, dc_b, busy_b, valid_b;
  logic [DB-1:0] rss_a, rss_b;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   armed = 1'b0;
  int   cuts_a = 0;

  exp_t          sb_a[$], sb_b[$];
  logic [15:0]   adcq_a[$], adcq_b[$];

  rss_sampler dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .lt5534_en(en_a), .adc_cs(cs_a), .dc_clk(dc_a), .adc_so(so_a),
    .busy(busy_a), .rss(rss_a), .rss_valid(valid_a)
  );

  rss_sampler #(
    .HALF_PERIOD(HB), .FRAME_BITS(FB), .DATA_BITS(DB), .AVG_LOG2(AB),
    .SETTLE_CYCLES(SB), .QUIET_CYCLES(QB)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .lt5534_en(en_b), .adc_cs(cs_b), .dc_clk(dc_b), .adc_so(so_b),
    .busy(busy_b), .rss(rss_b), .rss_valid(valid_b)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // ---------------- ADC models: drive a queued 16-bit word MSB first ----------------
  logic [15:0] cur_a, cur_b;
  int bit_a, bit_b, rises_a, rises_b, fall_a, fall_b, cuts_at_fall_a;
  bit open_a = 1'b0, open_b = 1'b0;

  always @(negedge cs_a) if (armed) begin
    cur_a = (adcq_a.size() > 0) ? adcq_a.pop_front() : 16'h0;
    bit_a = FB - 1; rises_a = 0; fall_a = cyc; open_a = 1'b1; cuts_at_fall_a = cuts_a;
  end
  always @(negedge dc_a) if (armed && !cs_a && bit_a >= 0) begin
    so_a = cur_a[bit_a]; bit_a--;
  end
  always @(posedge dc_a) if (open_a) rises_a++;
  always @(posedge cs_a) if (open_a) begin
    open_a = 1'b0;
    if (cuts_at_fall_a == cuts_a) begin
      check("cs_low_len_a", cyc - fall_a, WIN_A);
      check("sclk_rises_a", rises_a, FB);
    end
  end

  always @(negedge cs_b) if (armed) begin
    cur_b = (adcq_b.size() > 0) ? adcq_b.pop_front() : 16'h0;
    bit_b = FB - 1; rises_b = 0; fall_b = cyc; open_b = 1'b1;
  end
  always @(negedge dc_b) if (armed && !cs_b && bit_b >= 0) begin
    so_b = cur_b[bit_b]; bit_b--;
  end
  always @(posedge dc_b) if (open_b) rises_b++;
  always @(posedge cs_b) if (open_b) begin
    open_b = 1'b0;
    check("cs_low_len_b", cyc - fall_b, WIN_B);
    check("sclk_rises_b", rises_b, FB);
  end

  // ---------------- monitors ----------------
  always @(negedge clk) if (armed) begin
    exp_t e;
    check("en_eq_busy_a", en_a, busy_a);
    check("dc_idle_high_a", cs_a & ~dc_a, 0);
    if (valid_a) begin
      if (sb_a.size() == 0) check("valid_unexpected_a", valid_a, 0);
      else begin
        e = sb_a.pop_front();
        check("rss_a", rss_a, e.rss);
        check("valid_cyc_a", cyc, e.cyc);
      end
    end else if (sb_a.size() > 0 && cyc > sb_a[0].cyc) begin
      void'(sb_a.pop_front());
      check("valid_missing_a", valid_a, 1);
    end
  end

  always @(negedge clk) if (armed) begin
    exp_t e;
    check("en_eq_busy_b", en_b, busy_b);
    check("dc_idle_high_b", cs_b & ~dc_b, 0);
    if (valid_b) begin
      if (sb_b.size() == 0) check("valid_unexpected_b", valid_b, 0);
      else begin
        e = sb_b.pop_front();
        check("rss_b", rss_b, e.rss);
        check("valid_cyc_b", cyc, e.cyc);
      end
    end else if (sb_b.size() > 0 && cyc > sb_b[0].cyc) begin
      void'(sb_b.pop_front());
      check("valid_missing_b", valid_b, 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue_a(input logic [15:0] w [4], input bit expect_done, output int e0);
    int   sum;
    exp_t e;
    sum = 0;
    for (int i = 0; i < NA; i++) begin
      adcq_a.push_back(w[i]);
      sum += int'(w[i][DB-1:0]);
    end
    @(negedge clk);
    start_a = 1'b1;
    e0 = cyc + 1;
    if (expect_done) begin
      e.rss = sum / NA;
      e.cyc = e0 + LAT_A;
      sb_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic issue_b(input logic [15:0] w, output int e0);
    exp_t e;
    adcq_b.push_back(w);
    @(negedge clk);
    start_b = 1'b1;
    e0 = cyc + 1;
    e.rss = int'(w[DB-1:0]);
    e.cyc = e0 + LAT_B;
    sb_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic finish_a(input int e0);
    wait_to(e0 + LAT_A);
    check("busy_at_done_a", busy_a, 1);
    wait_to(e0 + LAT_A + 1);
    check("busy_after_done_a", busy_a, 0);
    check("en_after_done_a", en_a, 0);
    check("cs_after_done_a", cs_a, 1);
  endtask

  task automatic rand_words(output logic [15:0] w [4]);
    for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
  endtask

  initial begin
    logic [15:0] w [4];
    int e0;

    repeat (3) @(negedge clk);
    check("rst_cs_a", cs_a, 1);
    check("rst_dc_a", dc_a, 1);
    check("rst_en_a", en_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_rss_a", rss_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_cs_b", cs_b, 1);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    armed = 1'b1;
    repeat (2) @(negedge clk);

    // constant 0x0ABC on all frames
    w = '{16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC};
    issue_a(w, 1'b1, e0);
    check("busy_start_a", busy_a, 1);
    check("en_start_a", en_a, 1);
    wait_to(e0 + SA - 1);
    check("cs_before_f_a", cs_a, 1);
    wait_to(e0 + SA);
    check("cs_at_f_a", cs_a, 0);
    finish_a(e0);
    check("rss_hold_a", rss_a, 12'hABC);

    // 100,101,102,105 -> 102
    w = '{16'd100, 16'd101, 16'd102, 16'd105};
    issue_a(w, 1'b1, e0);
    finish_a(e0);

    // abort in the middle of the second frame
    rand_words(w);
    issue_a(w, 1'b0, e0);
    wait_to(e0 + 999);
    abort_a = 1'b1;
    cuts_a++;
    @(negedge clk);
    abort_a = 1'b0;
    adcq_a.delete();
    check("abort_cs_a", cs_a, 1);
    check("abort_dc_a", dc_a, 1);
    check("abort_en_a", en_a, 0);
    check("abort_busy_a", busy_a, 0);
    check("abort_rss_kept_a", rss_a, 12'h066);
    repeat (20) @(negedge clk);
    check("abort_stays_idle_a", busy_a, 0);

    // full scale, no wrap
    w = '{16'h0FFF, 16'h0FFF, 16'h0FFF, 16'h0FFF};
    issue_a(w, 1'b1, e0);
    finish_a(e0);

    // start re-pulsed while busy must be ignored
    rand_words(w);
    issue_a(w, 1'b1, e0);
    wait_to(e0 + 9);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_to(e0 + 1999);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    finish_a(e0);

    // start and abort together in idle
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    check("start_abort_busy_a", busy_a, 0);
    check("start_abort_en_a", en_a, 0);
    repeat (3) @(negedge clk);
    check("start_abort_cs_a", cs_a, 1);

    // reset in the middle of the first frame
    rand_words(w);
    issue_a(w, 1'b0, e0);
    wait_to(e0 + 299);
    reset = 1'b1;
    cuts_a++;
    @(negedge clk);
    reset = 1'b0;
    adcq_a.delete();
    check("mid_rst_cs_a", cs_a, 1);
    check("mid_rst_dc_a", dc_a, 1);
    check("mid_rst_en_a", en_a, 0);
    check("mid_rst_busy_a", busy_a, 0);
    check("mid_rst_rss_a", rss_a, 0);
    check("mid_rst_valid_a", valid_a, 0);
    repeat (5) @(negedge clk);

    // clean sequence after reset plus random runs
    for (int n = 0; n < 4; n++) begin
      rand_words(w);
      issue_a(w, 1'b1, e0);
      finish_a(e0);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    // fast corner: single frame, one-cycle half period
    issue_b(16'h0123, e0);
    wait_to(e0 + LAT_B);
    check("rss_direct_b", rss_b, 12'h123);
    wait_to(e0 + LAT_B + 1);
    check("busy_after_b", busy_b, 0);
    for (int n = 0; n < 6; n++) begin
      issue_b(16'($urandom), e0);
      wait_to(e0 + LAT_B + 1);
      check("busy_after_rand_b", busy_b, 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("sb_drained_a", sb_a.size(), 0);
    check("sb_drained_b", sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rss_sampler.md
Name: rss_sampler

Overview:
Sequencer for the LT5534 RSS detector and its serial ADC (adc_cs / dc_clk / adc_so).
- On a start pulse it powers the detector and waits for it to settle.
- It then runs 2^AVG_LOG2 SPI conversion frames and outputs the truncated average as an RSS code with a one-cycle valid.
- The tag state machine pulses start on B_START/N_START and consumes rss before the modulation window; it drives abort when trig drops.

Parameters:
HALF_PERIOD, 25, clk cycles per dc_clk half period (50 MHz -> 1 MHz SCLK); min 1
FRAME_BITS, 16, SCLK rising edges per conversion frame
DATA_BITS, 12, result bits = last DATA_BITS shifted in (LSB last)
AVG_LOG2, 2, log2 of conversions averaged per request (0..4)
SETTLE_CYCLES, 50, clk cycles lt5534_en is high before first CS fall; min 1
QUIET_CYCLES, 50, clk cycles CS held high between frames; min 1

Ports:
clk  in  1  50 MHz system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request pulse; ignored while busy
abort  in  1  cancel sequence (tied to ~trig / force_fs)
lt5534_en  out  1  detector enable, active-high
adc_cs  out  1  ADC chip select, active-low
dc_clk  out  1  ADC serial clock, idle high
adc_so  in  1  ADC serial data out
busy  out  1  sequence in progress
rss  out  DATA_BITS  averaged RSS code, holds last result
rss_valid  out  1  one-cycle pulse with new rss

Behaviour:
- All outputs registered.
- Reset values: adc_cs=1, dc_clk=1, lt5534_en=0, busy=0, rss=0, rss_valid=0, accumulator=0, state IDLE.
- States:
  - IDLE -> SETTLE on start.
  - SETTLE -> FRAME after SETTLE_CYCLES.
  - FRAME -> QUIET after CS rise if frames remain, else -> DONE.
  - QUIET -> FRAME after QUIET_CYCLES.
  - DONE -> IDLE after 1 cycle.
- Start edge E0: from E0 busy=1, lt5534_en=1, accumulator cleared, frame count=0.
- CS falls at E0+SETTLE_CYCLES (edge F).
- Frame timing, edges relative to F:
  - dc_clk falls at F+HALF_PERIOD.
  - dc_clk rises at F+2*HALF_PERIOD*k, k=1..FRAME_BITS.
  - adc_so is sampled at each clk edge where dc_clk is driven 0->1 and shifted in MSB first.
  - adc_cs rises at F+(2*FRAME_BITS+1)*HALF_PERIOD with dc_clk high.
- Result per frame: low DATA_BITS of the shift word, zero-extended and added to an accumulator of DATA_BITS+AVG_LOG2 bits. No overflow is possible.
- Frame stride = (2*FRAME_BITS+1)*HALF_PERIOD + QUIET_CYCLES. With defaults: 825 cycles low + 50 quiet = 875.
- Completion, on the edge where the last frame's CS rises:
  - rss <= (acc + last sample) >> AVG_LOG2 (truncation).
  - rss_valid <= 1 for exactly one cycle.
- With defaults, that edge is E0+3500; busy and lt5534_en drop at E0+3501.
- lt5534_en is high exactly while busy.
- start while busy: ignored, no restart, no queueing.
- abort (any state, priority below reset, above start):
  - Next edge: IDLE, adc_cs=1, dc_clk=1, lt5534_en=0, busy=0.
  - No rss_valid is issued; rss keeps its prior value.
  - abort and start on the same edge: stay IDLE.
  - abort in IDLE: no effect.
- Reset mid-sequence: same as abort, and additionally rss=0.
- AVG_LOG2=0: single frame, rss = sample.
- dc_clk never toggles while adc_cs=1.
- No glitch on adc_cs between frames shorter than QUIET_CYCLES.

Test Plan:
1. Defaults; ADC model returns 0x0ABC on all frames -> exactly 4 CS-low windows of 825 cycles each, 16 dc_clk rising edges per window; rss=0xABC, rss_valid single pulse at E0+3500; busy low at E0+3501.
2. Frames return 100, 101, 102, 105 -> sum 408 -> rss=102 (0x066). Frames all 0xFFF -> rss=0xFFF, no wrap.
3. abort asserted at E0+1000 (mid second frame) -> next cycle adc_cs=1, dc_clk=1, lt5534_en=0, busy=0; no rss_valid; rss unchanged from the previous result (e.g. 0x066).
4. start re-pulsed at E0+10 and E0+2000 -> ignored; sequence completes at E0+3500 with a single rss_valid. Simultaneous start+abort in IDLE -> stays IDLE, busy=0.
5. reset asserted at E0+300 -> all outputs at reset values (rss=0) next cycle. New start after reset -> a full clean sequence with correct timing.
6. HALF_PERIOD=1, AVG_LOG2=0, SETTLE_CYCLES=1, QUIET_CYCLES=1; ADC returns 0x0123 -> CS low for 33 cycles; rss=0x123 and rss_valid at E0+34.
